// File: rtl/axi4lite_rd_master.sv
// AXI4-Lite block read initiator: one outstanding read, each word forwarded on a valid/ready stream.
// Optional AXIRM_TIMEOUT_EN adds a per-wait-state abort after TIMEOUT cycles in ADDR or DATA.
module axi4lite_rd_master #(
  parameter int CNT_W   = 11,
  parameter int TIMEOUT = 255
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             ARVALID,
  input  logic             ARREADY,
  output logic [31:0]      ARADDR,
  input  logic             RVALID,
  output logic             RREADY,
  input  logic [31:0]      RDATA,
  input  logic [1:0]       RRESP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             done,
  output logic             err,
  output logic [31:0]      err_addr
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_OUT, S_DONE} state_t;

  state_t           state_reg;
  logic [31:0]      addr_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic [31:0]      start_addr;
  logic [31:0]      next_addr;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  // Low address bits are masked rather than dropped so the whole port is consumed.
  assign start_addr = {cmd_addr[31:2], cmd_addr[1:0] & 2'b00};
  assign next_addr  = addr_reg + 32'd4;

`ifdef AXIRM_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TO_W-1:0] to_cnt_reg;
  logic            to_hit;
  assign to_hit = (to_cnt_reg == TO_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      cmd_ready     <= 1'b1;
      ARVALID       <= 1'b0;
      ARADDR        <= '0;
      RREADY        <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_addr      <= '0;
`ifdef AXIRM_TIMEOUT_EN
      to_cnt_reg    <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef AXIRM_TIMEOUT_EN
      to_cnt_reg <= '0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_reg      <= start_addr;
            remaining_reg <= cmd_len;
            err           <= 1'b0;
            err_addr      <= '0;
            cmd_ready     <= 1'b0;
            if (cmd_len == '0) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              ARVALID   <= 1'b1;
              ARADDR    <= start_addr;
              state_reg <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (ARREADY) begin
            ARVALID   <= 1'b0;
            RREADY    <= 1'b1;
            state_reg <= S_DATA;
          end
`ifdef AXIRM_TIMEOUT_EN
          else if (to_hit) begin
            ARVALID   <= 1'b0;
            err       <= 1'b1;
            err_addr  <= addr_reg;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
`endif
        end
        S_DATA: begin
          if (RVALID) begin
            RREADY <= 1'b0;
            if (RRESP == 2'b00) begin
              out_data  <= RDATA;
              out_last  <= (remaining_reg == CNT_W'(1));
              out_valid <= 1'b1;
              state_reg <= S_OUT;
            end else begin
              err       <= 1'b1;
              err_addr  <= addr_reg;
              done      <= 1'b1;
              state_reg <= S_DONE;
            end
          end
`ifdef AXIRM_TIMEOUT_EN
          else if (to_hit) begin
            RREADY    <= 1'b0;
            err       <= 1'b1;
            err_addr  <= addr_reg;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
`endif
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid     <= 1'b0;
            remaining_reg <= remaining_reg - 1'b1;
            addr_reg      <= next_addr;
            if (remaining_reg == CNT_W'(1)) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              ARVALID   <= 1'b1;
              ARADDR    <= next_addr;
              state_reg <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_rd_master.sv
// Directed bench for axi4lite_rd_master with a small AXI4-Lite ROM slave and stream monitor.
// Defining AXIRM_TIMEOUT_EN also builds the DUT with TIMEOUT=16 and runs the hung-slave test.
module tb_axi4lite_rd_master;
  localparam int CNT_W = 11;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_addr = '0;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             ARVALID;
  logic             ARREADY = 1'b0;
  logic [31:0]      ARADDR;
  logic             RVALID = 1'b0;
  logic             RREADY;
  logic [31:0]      RDATA = '0;
  logic [1:0]       RRESP = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic             out_last;
  logic             done;
  logic             err;
  logic [31:0]      err_addr;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef AXIRM_TIMEOUT_EN
  axi4lite_rd_master #(.CNT_W(CNT_W), .TIMEOUT(16)) dut (
`else
  axi4lite_rd_master #(.CNT_W(CNT_W)) dut (
`endif
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .err(err), .err_addr(err_addr)
  );

  always #5 ACLK = ~ACLK;

  // Slave configuration and logs written only by the negedge process below.
  int          ar_lat = 1;
  int          r_lat = 1;
  bit          r_hang = 1'b0;
  logic [31:0] err_at = 32'hFFFF_FFFF;
  int          ar_cnt = 0, r_cnt = 0;
  logic [31:0] rd_addr = '0;
  logic [31:0] ar_log [64];
  logic [31:0] out_log [64];
  logic        last_log [64];
  int          rise_log [64];
  int          ar_n = 0, out_n = 0, done_n = 0, rise_n = 0, cyc = 0;
  logic        arv_prev = 1'b0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a < 32'h10) return 32'h11 * ((a >> 2) + 32'd1);
    return {16'hD00D, a[15:0]};
  endfunction

  always @(negedge ACLK) begin
    cyc = cyc + 1;
    if (!ARESETn) begin
      ARREADY = 1'b0; RVALID = 1'b0; ar_cnt = 0; r_cnt = 0; arv_prev = 1'b0;
    end else begin
      if (ARVALID && !arv_prev) begin rise_log[rise_n & 63] = cyc; rise_n = rise_n + 1; end
      arv_prev = ARVALID;
      if (ARREADY) ARREADY = 1'b0;
      else if (ARVALID) begin
        if (ar_cnt >= ar_lat) begin
          ARREADY = 1'b1; rd_addr = ARADDR; ar_cnt = 0;
          ar_log[ar_n & 63] = ARADDR; ar_n = ar_n + 1;
        end else ar_cnt = ar_cnt + 1;
      end
      if (RVALID) RVALID = 1'b0;
      else if (RREADY && !r_hang) begin
        if (r_cnt >= r_lat) begin
          RVALID = 1'b1; RDATA = rom(rd_addr);
          RRESP = (rd_addr == err_at) ? 2'b10 : 2'b00; r_cnt = 0;
        end else r_cnt = r_cnt + 1;
      end
      if (out_valid && out_ready) begin
        out_log[out_n & 63] = out_data; last_log[out_n & 63] = out_last; out_n = out_n + 1;
      end
      if (done) done_n = done_n + 1;
    end
  end

  task automatic issue_cmd(input logic [31:0] a, input logic [CNT_W-1:0] l);
    int k = 0;
    @(posedge ACLK); #1;
    while (!cmd_ready && k < 50) begin @(posedge ACLK); #1; k++; end
    n_cmp++;
    if (!cmd_ready) begin n_fail++; $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int k = 0;
    while (done_n == start && k < 400) begin @(negedge ACLK); k++; end
    repeat (3) @(negedge ACLK);
    n_cmp++;
    if (done_n - start != 1) begin
      n_fail++; $display("FAIL done_pulse: done cycles=%0d required 1", done_n - start);
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    n_cmp++;
    if ({cmd_ready, ARVALID, RREADY, out_valid, out_last, done, err} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 1000000",
                         {cmd_ready, ARVALID, RREADY, out_valid, out_last, done, err});
    end
    n_cmp++;
    if ({ARADDR, out_data, err_addr} !== 96'h0) begin
      n_fail++; $display("FAIL reset_words: ARADDR=%h out_data=%h err_addr=%h required 0",
                         ARADDR, out_data, err_addr);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int ob = out_n, ab = ar_n, db = done_n, rb = rise_n;
    logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    issue_cmd(32'h0, 11'd4);
    wait_done(db);
    n_cmp++;
    if (out_n - ob != 4 || ar_n - ab != 4) begin
      n_fail++; $display("FAIL basic_count: words=%0d ars=%0d required 4/4", out_n - ob, ar_n - ab);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_log[(ob + i) & 63] !== exp_d[i] || last_log[(ob + i) & 63] !== (i == 3) ||
          ar_log[(ab + i) & 63] !== 32'(4 * i)) begin
        n_fail++; $display("FAIL basic_word%0d: data=%h last=%b araddr=%h required %h %b %h", i,
                           out_log[(ob + i) & 63], last_log[(ob + i) & 63], ar_log[(ab + i) & 63],
                           exp_d[i], (i == 3), 32'(4 * i));
      end
    end
    n_cmp++;
    if (rise_log[(rb + 1) & 63] - rise_log[rb & 63] != 5) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles required 5",
                         rise_log[(rb + 1) & 63] - rise_log[rb & 63]);
    end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: err=%b required 0", err); end
    $display("test_basic done: %0d words", out_n - ob);
  endtask

  task automatic test_unaligned();
    int ob = out_n, ab = ar_n, db = done_n;
    issue_cmd(32'h13, 11'd1);
    wait_done(db);
    n_cmp++;
    if (ar_n - ab != 1 || ar_log[ab & 63] !== 32'h10) begin
      n_fail++; $display("FAIL unaligned_ar: ars=%0d addr=%h required 1 00000010", ar_n - ab, ar_log[ab & 63]);
    end
    n_cmp++;
    if (out_n - ob != 1 || out_log[ob & 63] !== 32'hD00D0010 || last_log[ob & 63] !== 1'b1) begin
      n_fail++; $display("FAIL unaligned_word: words=%0d data=%h last=%b required 1 d00d0010 1",
                         out_n - ob, out_log[ob & 63], last_log[ob & 63]);
    end
    $display("test_unaligned done");
  endtask

  task automatic test_zero_len();
    int ob = out_n, ab = ar_n, db = done_n;
    issue_cmd(32'h40, 11'd0);
    wait_done(db);
    n_cmp++;
    if (ar_n != ab || out_n != ob) begin
      n_fail++; $display("FAIL zero_len_bus: ars=%0d words=%0d required 0/0", ar_n - ab, out_n - ob);
    end
    $display("test_zero_len done");
  endtask

  task automatic test_error();
    int ob = out_n, ab = ar_n, db = done_n;
    err_at = 32'h104;
    issue_cmd(32'h100, 11'd3);
    wait_done(db);
    repeat (5) @(negedge ACLK);
    n_cmp++;
    if (out_n - ob != 1 || out_log[ob & 63] !== 32'hD00D0100 || last_log[ob & 63] !== 1'b0) begin
      n_fail++; $display("FAIL error_word: words=%0d data=%h last=%b required 1 d00d0100 0",
                         out_n - ob, out_log[ob & 63], last_log[ob & 63]);
    end
    n_cmp++;
    if (ar_n - ab != 2) begin n_fail++; $display("FAIL error_ar_count: got %0d required 2", ar_n - ab); end
    n_cmp++;
    if (err !== 1'b1 || err_addr !== 32'h104) begin
      n_fail++; $display("FAIL error_flag: err=%b err_addr=%h required 1 00000104", err, err_addr);
    end
    err_at = 32'hFFFF_FFFF;
    $display("test_error done");
  endtask

  task automatic test_stall();
    int ob = out_n, db = done_n, k = 0;
    logic [31:0] d;
    bit ok = 1'b1;
    out_ready = 1'b0;
    issue_cmd(32'h0, 11'd2);
    while (!out_valid && k < 50) begin @(negedge ACLK); k++; end
    d = out_data;
    repeat (10) begin
      @(negedge ACLK);
      if (out_data !== d || ARVALID !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    n_cmp++;
    if (!ok || d !== 32'h11) begin
      n_fail++; $display("FAIL stall_hold: stable=%b data=%h required 1 00000011", ok, d);
    end
    n_cmp++;
    if (err !== 1'b0 || err_addr !== 32'h0) begin
      n_fail++; $display("FAIL stall_err_clear: err=%b err_addr=%h required 0 0", err, err_addr);
    end
    @(posedge ACLK); #1;
    out_ready = 1'b1;
    wait_done(db);
    n_cmp++;
    if (out_n - ob != 2 || out_log[ob & 63] !== 32'h11 || out_log[(ob + 1) & 63] !== 32'h22 ||
        last_log[ob & 63] !== 1'b0 || last_log[(ob + 1) & 63] !== 1'b1) begin
      n_fail++; $display("FAIL stall_words: words=%0d d0=%h d1=%h required 2 11 22", out_n - ob,
                         out_log[ob & 63], out_log[(ob + 1) & 63]);
    end
    $display("test_stall done");
  endtask

  task automatic test_wrap_reset();
    int ob = out_n, ab = ar_n, db, k = 0;
    r_lat = 3;
    issue_cmd(32'hFFFF_FFFC, 11'd2);
    while (!(ar_n - ab == 2 && RREADY) && k < 100) begin @(negedge ACLK); k++; end
    db = done_n;
    ARESETn = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if ({cmd_ready, ARVALID, RREADY, out_valid, out_last, done, err} !== 7'b1000000) begin
      n_fail++; $display("FAIL midreset_flags: got %b required 1000000",
                         {cmd_ready, ARVALID, RREADY, out_valid, out_last, done, err});
    end
    n_cmp++;
    if ({ARADDR, out_data, err_addr} !== 96'h0) begin
      n_fail++; $display("FAIL midreset_words: ARADDR=%h out_data=%h err_addr=%h required 0",
                         ARADDR, out_data, err_addr);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    r_lat = 1;
    repeat (6) @(negedge ACLK);
    n_cmp++;
    if (done_n != db) begin n_fail++; $display("FAIL midreset_done: pulses=%0d required 0", done_n - db); end
    n_cmp++;
    if (ar_n - ab != 2 || ar_log[ab & 63] !== 32'hFFFF_FFFC || ar_log[(ab + 1) & 63] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_ar: ars=%0d a0=%h a1=%h required 2 fffffffc 00000000",
                         ar_n - ab, ar_log[ab & 63], ar_log[(ab + 1) & 63]);
    end
    n_cmp++;
    if (out_n - ob != 1 || out_log[ob & 63] !== 32'hD00DFFFC) begin
      n_fail++; $display("FAIL wrap_word: words=%0d data=%h required 1 d00dfffc", out_n - ob, out_log[ob & 63]);
    end
    $display("test_wrap_reset done");
  endtask

`ifdef AXIRM_TIMEOUT_EN
  task automatic test_timeout();
    int db = done_n, k = 0, hi = 0;
    r_hang = 1'b1;
    issue_cmd(32'h200, 11'd1);
    while (!RREADY && k < 50) begin @(negedge ACLK); k++; end
    while (RREADY && hi < 100) begin hi++; @(negedge ACLK); end
    n_cmp++;
    if (hi != 16) begin n_fail++; $display("FAIL timeout_cycles: RREADY high %0d required 16", hi); end
    wait_done(db);
    n_cmp++;
    if (err !== 1'b1 || err_addr !== 32'h200) begin
      n_fail++; $display("FAIL timeout_err: err=%b err_addr=%h required 1 00000200", err, err_addr);
    end
    r_hang = 1'b0;
    $display("test_timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_unaligned();
    test_zero_len();
    test_error();
    test_stall();
    test_wrap_reset();
`ifdef AXIRM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4lite_rd_master.md
Name: axi4lite_rd_master

Overview:
AXI4-Lite read initiator that fetches a block of consecutive 32-bit words from any AXI4-Lite read slave, for example the boot ROM.
- A simple command (start address, word count) is accepted.
- One read is issued at a time: one outstanding AR, no pipelining.
- Each returned word is forwarded on a valid/ready output stream.
- The block reports completion and the first bus error.
- It sits between the boot/fetch controller and the ROM/peripheral read port.

Parameters:
CNT_W, 11, width of cmd_len; max burst 2^CNT_W-1 words.
TIMEOUT, 255, cycles allowed per wait state before abort (used only with AXIRM_TIMEOUT_EN).

Ports:
ACLK  in  1  clock; all logic on the rising edge
ARESETn  in  1  synchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_addr  in  32  start byte address; bits [1:0] ignored (forced to 00)
cmd_len  in  CNT_W  number of words to read
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
ARADDR  out  32  read address, always word-aligned
RVALID  in  1  read data valid
RREADY  out  1  read data ready
RDATA  in  32  read data
RRESP  in  2  read response
out_valid  out  1  output word valid
out_ready  in  1  output word accepted
out_data  out  32  output word
out_last  out  1  marks final word of the command
done  out  1  one-cycle completion pulse
err  out  1  sticky error flag; cleared on next accepted command
err_addr  out  32  ARADDR of the first failing read

Behaviour:
- Reset values (ARESETn low at a rising edge): state=IDLE, cmd_ready=1, ARVALID=0, ARADDR=0, RREADY=0, out_valid=0, out_data=0, out_last=0, done=0, err=0, err_addr=0.
- Reset mid-operation abandons the transfer immediately with no done pulse.
- States: IDLE, ADDR, DATA, OUT, DONE.
- IDLE:
  - cmd_valid&&cmd_ready: latch addr={cmd_addr[31:2],2'b00}, remaining=cmd_len, clear err.
  - If cmd_len==0, go to DONE; no bus activity.
  - Otherwise go to ADDR. ARVALID is high the cycle after acceptance.
- ADDR:
  - ARVALID=1 with ARADDR=addr, held stable until ARVALID&&ARREADY.
  - ARVALID never drops before the handshake. No combinational dependence on ARREADY.
  - Handshake: ARVALID<=0, go to DATA.
- DATA:
  - RREADY=1. On RVALID&&RREADY, capture RDATA and RREPLY, and drop RREADY.
  - RRESP==00: out_data<=RDATA, out_last<=(remaining==1), go to OUT.
  - RRESP!=00 (any nonzero value is an error): set err, err_addr<=addr, discard data, go to DONE.
- OUT:
  - out_valid=1; out_data and out_last stay stable until out_ready.
  - On accept: remaining-=1, addr+=4. Address wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - If remaining was 1, go to DONE; else go to ADDR.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 here.
- Minimum per-word latency with a slave giving ARREADY after 1 cycle and RVALID after 1 cycle: 5 cycles from ARVALID rise to the next ARVALID rise, with out_ready tied high.
- Simultaneous events:
  - out_ready held low stalls the FSM in OUT; no new AR is issued.
  - RVALID in ADDR before the AR handshake is a slave protocol violation and is ignored.
- err and err_addr persist until the next command is accepted.

Optional Feature:
AXIRM_TIMEOUT_EN
- Defined:
  - An 8+ bit counter (sized by TIMEOUT) runs in ADDR and DATA and clears on every state change.
  - Reaching TIMEOUT sets err, err_addr<=addr, drops ARVALID/RREADY, and goes to DONE.
  - Dropping ARVALID here is a documented abort of a hung bus; the system must reset the slave.
- Undefined: no counter; the FSM waits indefinitely in ADDR/DATA.

Test Plan:
- Reset then cmd_addr=0x0000_0000, cmd_len=4 against ROM model words 0x11,0x22,0x33,0x44 -> out_data 0x11,0x22,0x33,0x44; out_last only on 0x44; ARADDR 0x0,0x4,0x8,0xC; done one pulse; err=0.
- cmd_addr=0x0000_0013, cmd_len=1 -> ARADDR=0x0000_0010; single word with out_last=1.
- cmd_len=3, slave returns RRESP=2'b10 on the 2nd read at 0x104 (start 0x100) -> one output word only; err=1; err_addr=0x104; done pulse; no 3rd AR.
- out_ready held low 10 cycles on the first word -> out_data stable, ARVALID stays 0, no word lost; then the sequence resumes normally.
- cmd_addr=0xFFFF_FFFC, cmd_len=2 -> ARADDR 0xFFFFFFFC then 0x00000000. ARESETn low during the 2nd DATA state -> all outputs at reset values next cycle; no done pulse.
- With AXIRM_TIMEOUT_EN, TIMEOUT=16, slave never asserts RVALID -> RREADY drops after 16 cycles in DATA; err=1; err_addr=issued ARADDR; done pulse.
